csr_host_bridge: RTL
====================

Name: csr_host_bridge

Overview:
Byte-stream command decoder. It sits between the UART RX/TX byte FIFOs and the csr block, and acts as the bus initiator for csr_wen/csr_ren/csr_addr/csr_wdata/csr_rdata. It parses host frames, optionally checks CRC-8, issues a single CSR access, and returns an ack or read-data response frame on the TX byte stream. It also generates the rx_crc_error and rx_illegal_cmd pulses consumed by csr.

Parameters:
ADDR_W, 8, CSR byte-address width; must match csr.ADDR_W
TIMEOUT_CYC, 100000, max idle cycles between bytes of one frame before abort
CRC_POLY, 8'h07, CRC-8 polynomial (MSB-first, init 8'h00, no reflect, no xorout)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  rx byte available
rx_ready  out  1  byte consumed when rx_valid&&rx_ready
tx_data  out  8  response byte
tx_valid  out  1  response byte available
tx_ready  in  1  byte taken when tx_valid&&tx_ready
crc_en  in  1  from csr uart_crc_en; sampled at frame start
csr_wen  out  1  one-cycle write strobe
csr_ren  out  1  one-cycle read strobe
csr_addr  out  ADDR_W  CSR byte address
csr_wdata  out  32  write data
csr_rdata  in  32  read data, valid the cycle after csr_ren
rx_crc_error  out  1  one-cycle pulse on CRC mismatch
rx_illegal_cmd  out  1  one-cycle pulse on unknown opcode or frame timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; tx_data 8'h00; state IDLE; crc_q 8'h00; crc_en_q 0.
- Frames are little-endian. WRITE = 0x57, ADDR, D0..D3, [CRC]. READ = 0x52, ADDR, [CRC]. CRC covers every preceding byte of the frame, including the opcode.
- Responses: write ack = 0xA1; read = 0xA2, R0..R3 (LE); error = 0xEE, code (0x01 CRC, 0x02 illegal, 0x03 timeout).
- rx_ready = 1 in IDLE, ADDR, DATA and CRC; 0 otherwise. Input back-pressure is the only flow control.
- IDLE: on an accepted byte, latch crc_en into crc_en_q and start the CRC from that byte.
  - 0x57 -> ADDR(wr); 0x52 -> ADDR(rd).
  - Any other byte: pulse rx_illegal_cmd, then RESP with error 0x02.
- ADDR: latch csr_addr. Write -> DATA; read -> CRC if crc_en_q, else EXEC.
- DATA: 2-bit byte counter; byte i goes to csr_wdata[8i+7:8i]. After the 4th byte -> CRC if crc_en_q, else EXEC.
- CRC: compare the received byte with crc_q.
  - Match -> EXEC.
  - Mismatch: pulse rx_crc_error, no CSR access, RESP with error 0x01.
- EXEC: one cycle. Write: csr_wen=1 -> RESP(0xA1). Read: csr_ren=1 -> RD_WAIT.
- RD_WAIT: one cycle; capture csr_rdata into a 32-bit shift register -> RESP(0xA2 + 4 bytes).
- RESP: emit bytes in order and hold tx_data stable while tx_valid && !tx_ready. After the last accepted byte -> IDLE.
- Timeout: a counter resets on every accepted byte and runs only in ADDR/DATA/CRC.
  - When it reaches TIMEOUT_CYC: pulse rx_illegal_cmd, discard the partial frame, RESP with error 0x03.
- csr_addr and csr_wdata hold their last values outside EXEC; they are only meaningful while a strobe is high.
- csr_wen and csr_ren are never high in the same cycle. At most one CSR access occurs per frame.
- crc_en changing mid-frame has no effect; crc_en_q is used for the whole frame.
- Error pulses are exactly one cycle, even when the tx side is stalled.
- Asynchronous reset mid-frame or mid-response: immediate return to IDLE; partial TX is abandoned and tx_valid drops.

Decomposition:
- Package csr_host_pkg:
  - opcode constants (OP_WR, OP_RD)
  - response codes (RSP_ACK, RSP_RD, RSP_ERR)
  - error codes (ERR_CRC, ERR_ILL, ERR_TMO)
  - state enum (IDLE, ADDR, DATA, CRC, EXEC, RD_WAIT, RESP)
- Sub-module crc8_byte: combinational next_crc = f(crc_in, byte_in), parameterised by CRC_POLY. The bridge owns the crc_q register.

Test Plan:
- crc_en=0; send 57 28 0D 00 00 00 -> one-cycle csr_wen with addr 0x28, wdata 0x0000000D; TX = A1.
- csr_rdata=0x000003E8 at addr 0x40; send 52 40 -> csr_ren, then TX = A2 E8 03 00 00.
- crc_en=1; send 52 04 with a correct CRC -> read occurs. Repeat with CRC^0x01 -> rx_crc_error pulse, no csr_ren, TX = EE 01.
- Send 0x33 -> rx_illegal_cmd pulse, TX = EE 02, csr_wen and csr_ren both stay 0.
- TIMEOUT_CYC=16; send 57 10 then stall 16 cycles -> rx_illegal_cmd pulse, TX = EE 03, no csr_wen. A following valid frame is accepted normally.
- tx_ready low for 5 cycles mid read response -> tx_data stable, no byte lost. Assert rst_n=0 mid-response -> all outputs 0 immediately, next frame decoded correctly.

Source files
------------

// File: rtl/csr_host_pkg.sv
// rtl/csr_host_pkg.sv - shared opcodes, response codes and state encoding for csr_host_bridge
package csr_host_pkg;

   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;

   localparam logic [7:0] RSP_ACK = 8'hA1;
   localparam logic [7:0] RSP_RD  = 8'hA2;
   localparam logic [7:0] RSP_ERR = 8'hEE;

   localparam logic [7:0] ERR_CRC = 8'h01;
   localparam logic [7:0] ERR_ILL = 8'h02;
   localparam logic [7:0] ERR_TMO = 8'h03;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ADDR    = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_CRC     = 3'd3;
   localparam logic [2:0] ST_EXEC    = 3'd4;
   localparam logic [2:0] ST_RD_WAIT = 3'd5;
   localparam logic [2:0] ST_RESP    = 3'd6;

   // Response shift register image: first byte to send sits in the top byte.
   function automatic logic [39:0] err_frame(input logic [7:0] code);
      return {RSP_ERR, code, 24'h000000};
   endfunction

endpackage

// File: rtl/crc8_byte.sv
// rtl/crc8_byte.sv - combinational CRC-8 update over one byte, MSB first
module crc8_byte #(
   parameter logic [7:0] CRC_POLY = 8'h07
) (
   input  logic [7:0] crc_in,
   input  logic [7:0] byte_in,
   output logic [7:0] crc_out
);

   logic [7:0] c;

   always_comb begin
      c = crc_in ^ byte_in;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/csr_host_bridge.sv
// rtl/csr_host_bridge.sv - host byte-frame decoder driving one CSR access per frame
module csr_host_bridge
   import csr_host_pkg::*;
#(
   parameter int         ADDR_W      = 8,
   parameter int         TIMEOUT_CYC = 100000,
   parameter logic [7:0] CRC_POLY    = 8'h07
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic              crc_en,
   output logic              csr_wen,
   output logic              csr_ren,
   output logic [ADDR_W-1:0] csr_addr,
   output logic [31:0]       csr_wdata,
   input  logic [31:0]       csr_rdata,
   output logic              rx_crc_error,
   output logic              rx_illegal_cmd,
   output logic              busy
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [2:0]    state;
   logic          is_wr;
   logic          crc_en_q;
   logic [7:0]    crc_q;
   logic [7:0]    crc_nxt;
   logic [1:0]    byte_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [39:0]   rsp_sr;
   logic [2:0]    rsp_left;
   logic          rx_acc;
   logic          in_frame;
   logic          tmo_hit;

   crc8_byte #(.CRC_POLY(CRC_POLY)) u_crc (
      .crc_in  ((state == ST_IDLE) ? 8'h00 : crc_q),
      .byte_in (rx_data),
      .crc_out (crc_nxt)
   );

   assign in_frame = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CRC);
   assign rx_ready = (state == ST_IDLE) || in_frame;
   assign rx_acc   = rx_valid && rx_ready;
   // An arriving byte always wins over an expiring timeout in the same cycle.
   assign tmo_hit  = in_frame && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
   assign tx_valid = (state == ST_RESP);
   assign tx_data  = rsp_sr[39:32];
   assign csr_wen  = (state == ST_EXEC) && is_wr;
   assign csr_ren  = (state == ST_EXEC) && !is_wr;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         is_wr          <= 1'b0;
         crc_en_q       <= 1'b0;
         crc_q          <= 8'h00;
         byte_cnt       <= 2'd0;
         tmo_cnt        <= '0;
         rsp_sr         <= 40'h0;
         rsp_left       <= 3'd0;
         csr_addr       <= '0;
         csr_wdata      <= 32'h0;
         rx_crc_error   <= 1'b0;
         rx_illegal_cmd <= 1'b0;
      end else begin
         rx_crc_error   <= 1'b0;
         rx_illegal_cmd <= 1'b0;
         if (rx_acc) crc_q <= crc_nxt;
         if (rx_acc || !in_frame) tmo_cnt <= '0;
         else                     tmo_cnt <= tmo_cnt + 1'b1;

         if (tmo_hit) begin
            rx_illegal_cmd <= 1'b1;
            rsp_sr         <= err_frame(ERR_TMO);
            rsp_left       <= 3'd2;
            state          <= ST_RESP;
         end else begin
            case (state)
               ST_IDLE: if (rx_acc) begin
                  crc_en_q <= crc_en;
                  byte_cnt <= 2'd0;
                  if (rx_data == OP_WR || rx_data == OP_RD) begin
                     is_wr <= (rx_data == OP_WR);
                     state <= ST_ADDR;
                  end else begin
                     rx_illegal_cmd <= 1'b1;
                     rsp_sr         <= err_frame(ERR_ILL);
                     rsp_left       <= 3'd2;
                     state          <= ST_RESP;
                  end
               end
               ST_ADDR: if (rx_acc) begin
                  csr_addr <= ADDR_W'(rx_data);
                  if (is_wr)         state <= ST_DATA;
                  else if (crc_en_q) state <= ST_CRC;
                  else               state <= ST_EXEC;
               end
               ST_DATA: if (rx_acc) begin
                  csr_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) state <= crc_en_q ? ST_CRC : ST_EXEC;
               end
               ST_CRC: if (rx_acc) begin
                  if (rx_data == crc_q) begin
                     state <= ST_EXEC;
                  end else begin
                     rx_crc_error <= 1'b1;
                     rsp_sr       <= err_frame(ERR_CRC);
                     rsp_left     <= 3'd2;
                     state        <= ST_RESP;
                  end
               end
               ST_EXEC: begin
                  if (is_wr) begin
                     rsp_sr   <= {RSP_ACK, 32'h0};
                     rsp_left <= 3'd1;
                     state    <= ST_RESP;
                  end else begin
                     state <= ST_RD_WAIT;
                  end
               end
               ST_RD_WAIT: begin
                  rsp_sr   <= {RSP_RD, csr_rdata[7:0], csr_rdata[15:8],
                               csr_rdata[23:16], csr_rdata[31:24]};
                  rsp_left <= 3'd5;
                  state    <= ST_RESP;
               end
               ST_RESP: if (tx_ready) begin
                  rsp_sr   <= rsp_sr << 8;
                  rsp_left <= rsp_left - 3'd1;
                  if (rsp_left == 3'd1) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
